// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// Bit and frame timing for an oversampling serial receiver. Each bit lasts
// P clock cycles (P = latched Prescale); each frame holds F bits (F = latched
// frame_len, start and stop bits included). The block provides the position
// counters, a three-cycle majority-vote sample window centred in the bit, and
// end-of-bit / end-of-frame pulses.
//
// Ports
//   CLK          single clock, all state changes on its rising edge
//   RST          asynchronous active-low reset
//   enable       frame timing runs while high; P and F are latched while low
//   resync       synchronous clear of both counters while enabled
//   Prescale     clock cycles per bit (even, 6 .. 2^PRESCALE_WIDTH-2)
//   frame_len    bits per frame (>= 2)
//   edge_cnt     cycle position inside the current bit
//   bit_cnt      bit position inside the current frame
//   sample_en    high on edge_cnt in {P/2-1, P/2, P/2+1}
//   sample_last  high on edge_cnt == P/2+1 only
//   bit_done     pulse on the last cycle of each bit
//   frame_done   pulse on the last cycle of each frame
//   cfg_err      latched configuration is illegal; timing is frozen at 0
module rx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      resync,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [BIT_CNT_WIDTH-1:0]  frame_len,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      sample_en,
  output logic                      sample_last,
  output logic                      bit_done,
  output logic                      frame_done,
  output logic                      cfg_err
);

  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] P_MIN = PRESCALE_WIDTH'(6);
  // Largest legal prescale: all ones except the LSB (2^W - 2).
  localparam logic [PRESCALE_WIDTH-1:0] P_MAX = {{(PRESCALE_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [BIT_CNT_WIDTH-1:0]  F_ONE = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  F_MIN = BIT_CNT_WIDTH'(2);

  logic [PRESCALE_WIDTH-1:0] p_reg;
  logic [BIT_CNT_WIDTH-1:0]  f_reg;

  logic [PRESCALE_WIDTH-1:0] p_last;
  logic [PRESCALE_WIDTH-1:0] p_half;
  logic [BIT_CNT_WIDTH-1:0]  f_last;
  logic                      at_bit_end;
  logic                      at_frame_end;
  logic                      in_window;

  // Configuration is only sampled while timing is idle, so a running frame
  // never sees its bit period or length change underneath it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_reg <= '0;
      f_reg <= '0;
    end else if (!enable) begin
      p_reg <= Prescale;
      f_reg <= frame_len;
    end
  end

  // Reset leaves P=F=0, which decodes as illegal until the first capture.
  assign cfg_err = p_reg[0] | (p_reg < P_MIN) | (p_reg > P_MAX) | (f_reg < F_MIN);

  assign p_last       = p_reg - P_ONE;
  assign p_half       = p_reg >> 1;
  assign f_last       = f_reg - F_ONE;
  assign at_bit_end   = (edge_cnt == p_last);
  assign at_frame_end = (bit_cnt == f_last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (cfg_err || !enable || resync) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (at_bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= at_frame_end ? '0 : bit_cnt + F_ONE;
    end else begin
      edge_cnt <= edge_cnt + P_ONE;
    end
  end

  // Sample window is not gated by resync: a resync only re-aligns the
  // counters, the sample taken in the same cycle is still meaningful.
  assign in_window = (edge_cnt == p_half - P_ONE) ||
                     (edge_cnt == p_half) ||
                     (edge_cnt == p_half + P_ONE);

  assign sample_en   = enable & ~cfg_err & in_window;
  assign sample_last = enable & ~cfg_err & (edge_cnt == p_half + P_ONE);
  assign bit_done    = enable & ~resync & ~cfg_err & at_bit_end;
  assign frame_done  = bit_done & at_frame_end;

endmodule

// File: tb/tb_rx_bit_timer.sv
module tb_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK;
  logic          RST;
  logic          enable;
  logic          resync;
  logic [PW-1:0] Prescale;
  logic [BW-1:0] frame_len;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_en;
  logic          sample_last;
  logic          bit_done;
  logic          frame_done;
  logic          cfg_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: configuration latched while idle plus the number of
  // enabled cycles k since the last start/resync; positions follow from k.
  int mp = 0;
  int mf = 0;
  int k  = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic          en;
    logic          rs;
    logic [PW-1:0] exp_edge;
    logic [BW-1:0] exp_bit;
    logic          exp_sen;
    logic          exp_slast;
    logic          exp_bdone;
    logic          exp_fdone;
    logic          exp_err;
  } vec_t;

  vec_t vecs[12];

  rx_bit_timer #(.PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .resync(resync),
    .Prescale(Prescale), .frame_len(frame_len),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_en(sample_en), .sample_last(sample_last),
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_err();
    return (mp % 2 == 1) || (mp < 6) || (mp > (1 << PW) - 2) || (mf < 2);
  endfunction

  task automatic compare_model();
    bit err;
    int e, b;
    bit bd, fd, sen, sl;
    err = model_err();
    e   = err ? 0 : k % mp;
    b   = err ? 0 : (k / mp) % mf;
    bd  = enable && !resync && !err && (e == mp - 1);
    fd  = bd && (b == mf - 1);
    sen = enable && !err && (e >= mp / 2 - 1) && (e <= mp / 2 + 1);
    sl  = enable && !err && (e == mp / 2 + 1);
    check("model_cfg_err",     32'(cfg_err),     32'(err));
    check("model_edge_cnt",    32'(edge_cnt),    32'(e));
    check("model_bit_cnt",     32'(bit_cnt),     32'(b));
    check("model_bit_done",    32'(bit_done),    32'(bd));
    check("model_frame_done",  32'(frame_done),  32'(fd));
    check("model_sample_en",   32'(sample_en),   32'(sen));
    check("model_sample_last", 32'(sample_last), 32'(sl));
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; one rising edge is taken, the model is
  // advanced with the inputs the DUT saw, and outputs are checked at the next
  // falling edge.
  task automatic tick(input logic en, input logic rs);
    enable = en;
    resync = rs;
    @(posedge CLK);
    if (!RST) begin
      mp = 0; mf = 0; k = 0;
    end else if (!enable) begin
      mp = int'(Prescale); mf = int'(frame_len); k = 0;
    end else if (resync) begin
      k = 0;
    end else begin
      k++;
    end
    @(negedge CLK);
    compare_model();
  endtask

  task automatic start_cfg(input int pre, input int fl);
    Prescale  = PW'(pre);
    frame_len = BW'(fl);
    tick(1'b0, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bd_count;
    int fd_count;
    int strobe_count;
    logic [15:0] got;

    RST = 1'b0; enable = 1'b0; resync = 1'b0;
    Prescale = PW'(8); frame_len = BW'(10);

    // Reset state: counters 0, P=F=0 decodes as illegal.
    @(negedge CLK); @(negedge CLK);
    check("reset_edge_cnt", 32'(edge_cnt), 0);
    check("reset_bit_cnt",  32'(bit_cnt), 0);
    check("reset_cfg_err",  32'(cfg_err), 1);
    RST = 1'b1;

    // P=8, F=10 directed table (first entry captures the configuration).
    vecs[0]  = '{1'b0, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 6'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 6'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 6'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 6'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 6'd5, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 6'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 6'd7, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 6'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 6'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].en, vecs[i].rs);
      check($sformatf("vec%0d_edge_cnt", i),    32'(edge_cnt),    32'(vecs[i].exp_edge));
      check($sformatf("vec%0d_bit_cnt", i),     32'(bit_cnt),     32'(vecs[i].exp_bit));
      check($sformatf("vec%0d_sample_en", i),   32'(sample_en),   32'(vecs[i].exp_sen));
      check($sformatf("vec%0d_sample_last", i), 32'(sample_last), 32'(vecs[i].exp_slast));
      check($sformatf("vec%0d_bit_done", i),    32'(bit_done),    32'(vecs[i].exp_bdone));
      check($sformatf("vec%0d_frame_done", i),  32'(frame_done),  32'(vecs[i].exp_fdone));
      check($sformatf("vec%0d_cfg_err", i),     32'(cfg_err),     32'(vecs[i].exp_err));
    end

    // Two full frames at P=8, F=10: frame_done on cycles 79 and 159.
    start_cfg(8, 10);
    for (int i = 1; i <= 160; i++) if (i % 80 == 79) exp_q.push_back(16'(i));
    bd_count = 0;
    for (int i = 1; i <= 160; i++) begin
      tick(1'b1, 1'b0);
      if (bit_done) bd_count++;
      if (frame_done) begin
        if (exp_q.size() == 0) check("frame_done_unexpected", 32'(i), 0);
        else begin
          got = exp_q.pop_front();
          check("frame_done_cycle", 32'(i), 32'(got));
        end
      end
    end
    check("frame_done_missing", 32'(exp_q.size()), 0);
    check("bit_done_count_160", 32'(bd_count), 20);

    // Resync mid-bit at edge 5, bit 3.
    start_cfg(8, 10);
    run(29);
    check("pre_resync_edge", 32'(edge_cnt), 5);
    check("pre_resync_bit",  32'(bit_cnt), 3);
    resync = 1'b1; #1;
    check("resync_mid_bit_done", 32'(bit_done), 0);
    tick(1'b1, 1'b1);
    check("resync_mid_edge", 32'(edge_cnt), 0);
    check("resync_mid_bit",  32'(bit_cnt), 0);

    // Resync on the last cycle of the last bit suppresses both pulses.
    start_cfg(8, 10);
    run(79);
    check("last_cycle_bit_done",   32'(bit_done), 1);
    check("last_cycle_frame_done", 32'(frame_done), 1);
    resync = 1'b1; #1;
    check("resync_end_bit_done",   32'(bit_done), 0);
    check("resync_end_frame_done", 32'(frame_done), 0);
    tick(1'b1, 1'b1);
    check("resync_end_edge", 32'(edge_cnt), 0);
    check("resync_end_bit",  32'(bit_cnt), 0);

    // Illegal configurations: odd prescale, then a one-bit frame.
    for (int c = 0; c < 2; c++) begin
      if (c == 0) start_cfg(7, 10); else start_cfg(8, 1);
      check($sformatf("illegal%0d_cfg_err", c), 32'(cfg_err), 1);
      strobe_count = 0;
      for (int i = 0; i < 20; i++) begin
        tick(1'b1, 1'b0);
        if (sample_en || sample_last || bit_done || frame_done || edge_cnt != 0 || bit_cnt != 0)
          strobe_count++;
      end
      check($sformatf("illegal%0d_activity", c), 32'(strobe_count), 0);
    end

    // Prescale change while running is held off until enable drops.
    start_cfg(8, 10);
    Prescale = PW'(16);
    bd_count = 0;
    for (int i = 0; i < 24; i++) begin tick(1'b1, 1'b0); if (bit_done) bd_count++; end
    check("held_period_bit_done", 32'(bd_count), 3);
    tick(1'b0, 1'b0);
    bd_count = 0;
    for (int i = 0; i < 32; i++) begin tick(1'b1, 1'b0); if (bit_done) bd_count++; end
    check("new_period_bit_done", 32'(bd_count), 2);

    // Asynchronous reset mid-frame at bit 4, edge 6.
    start_cfg(8, 10);
    run(38);
    check("pre_reset_edge", 32'(edge_cnt), 6);
    check("pre_reset_bit",  32'(bit_cnt), 4);
    RST = 1'b0; #1;
    check("async_reset_edge",       32'(edge_cnt), 0);
    check("async_reset_bit",        32'(bit_cnt), 0);
    check("async_reset_cfg_err",    32'(cfg_err), 1);
    check("async_reset_frame_done", 32'(frame_done), 0);
    tick(1'b1, 1'b0);
    RST = 1'b1;
    start_cfg(8, 10);
    check("post_reset_cfg_err", 32'(cfg_err), 0);

    // Randomized bursts against the model.
    for (int burst = 0; burst < 10; burst++) begin
      int pre_list[9] = '{6, 8, 10, 16, 62, 7, 4, 63, 12};
      start_cfg(pre_list[$urandom_range(0, 8)], $urandom_range(0, 15));
      for (int i = 0; i < int'($urandom_range(40, 160)); i++) begin
        if ($urandom_range(0, 15) == 0) Prescale = PW'($urandom_range(0, 63));
        if ($urandom_range(0, 15) == 0) frame_len = BW'($urandom_range(0, 15));
        tick(($urandom_range(0, 39) != 0), ($urandom_range(0, 24) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
